// File: rtl/uart_lcd_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_lcd_framer_pkg
//  Description : Shared types and constants for the UART-to-LCD byte framer:
//                FSM state encoding, byte classes, the {rs, data} LCD
//                transaction struct, ASCII control codes and HD44780 commands.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_lcd_framer_pkg;

    // Framer FSM states
    typedef logic [1:0] state_t;
    localparam state_t S_NORM = 2'd0;   // classify incoming bytes
    localparam state_t S_ESC  = 2'd1;   // next byte is a raw command
    localparam state_t S_WRAP = 2'd2;   // line-wrap command pending, input stalled

    // Result of decoding one received byte in normal mode
    typedef enum logic [2:0] {
        CL_PRINT = 3'd0,
        CL_CR    = 3'd1,
        CL_LF    = 3'd2,
        CL_FF    = 3'd3,
        CL_ESC   = 3'd4,
        CL_DROP  = 3'd5
    } char_class_t;

    // One LCD FIFO entry: rs=1 writes character data, rs=0 issues a command
    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_txn_t;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] PRINT_LO   = 8'h20;
    localparam logic [7:0] PRINT_HI   = 8'h7E;

    localparam logic [7:0] LINE0_ADDR = 8'h80;
    localparam logic [7:0] LINE1_ADDR = 8'hC0;
    localparam logic [7:0] CLEAR_CMD  = 8'h01;

    // Set-DDRAM-address command for the start of the given display line
    function automatic logic [7:0] line_addr(input logic row);
        return row ? LINE1_ADDR : LINE0_ADDR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_lcd_framer_classify.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_char_classify
//  Description : Combinational decode of one received byte into its class
//                and the LCD transaction it would produce in normal mode,
//                given the current cursor row.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_char_classify
    import uart_lcd_framer_pkg::*;
#(
    parameter logic [7:0] ESC_CHAR = 8'h1B
) (
    input  logic [7:0]  i_data,
    input  logic        i_row,
    output char_class_t o_class,
    output lcd_txn_t    o_txn
);

    // Escape prefix takes priority so a printable ESC_CHAR still acts as prefix
    always_comb begin
        o_class = CL_DROP;
        o_txn   = '0;
        if (i_data == ESC_CHAR) begin
            o_class = CL_ESC;
        end else if (i_data >= PRINT_LO && i_data <= PRINT_HI) begin
            o_class = CL_PRINT;
            o_txn   = '{rs: 1'b1, data: i_data};
        end else if (i_data == CHAR_CR) begin
            o_class = CL_CR;
            o_txn   = '{rs: 1'b0, data: line_addr(i_row)};
        end else if (i_data == CHAR_LF) begin
            o_class = CL_LF;
            o_txn   = '{rs: 1'b0, data: line_addr(!i_row)};
        end else if (i_data == CHAR_FF) begin
            o_class = CL_FF;
            o_txn   = '{rs: 1'b0, data: CLEAR_CMD};
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_lcd_framer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_lcd_framer
//  Description : Frames UART RX bytes into 9-bit {rs, data} HD44780
//                transactions for the LCD FIFO, tracks the cursor on a
//                2-line display and maps CR/LF/FF/escape to commands.
//                Define UART_LCD_FRAMER_AUTOWRAP_EN to emit a set-DDRAM
//                command whenever a character fills the last column.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_lcd_framer
    import uart_lcd_framer_pkg::*;
#(
    parameter int         COLS     = 16,
    parameter logic [7:0] ESC_CHAR = 8'h1B
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8:0]              out_txn,
    output logic                    cur_row,
    output logic [$clog2(COLS)-1:0] cur_col,
    output logic                    err_pulse
);

    localparam int              CW         = $clog2(COLS);
    localparam logic [CW-1:0]   c_COL_LAST = CW'(COLS - 1);

    state_t          r_state;
    lcd_txn_t        r_out_txn;
    logic            r_out_valid;
    logic            r_row;
    logic [CW-1:0]   r_col;
    logic            r_err;
`ifdef UART_LCD_FRAMER_AUTOWRAP_EN
    logic            r_wrap_loaded;   // wrap command has replaced the character
`endif

    char_class_t     w_class;
    lcd_txn_t        w_txn;
    logic            w_accept;
    logic            w_xfer;
    logic            w_col_last;

    lcd_char_classify #(
        .ESC_CHAR (ESC_CHAR)
    ) u_classify (
        .i_data  (in_data),
        .i_row   (r_row),
        .o_class (w_class),
        .o_txn   (w_txn)
    );

    assign w_xfer     = r_out_valid && out_ready;
    assign in_ready   = (!r_out_valid || out_ready) && (r_state != S_WRAP);
    assign w_accept   = in_valid && in_ready;
    assign w_col_last = (r_col == c_COL_LAST);

    assign out_valid  = r_out_valid;
    assign out_txn    = r_out_txn;
    assign cur_row    = r_row;
    assign cur_col    = r_col;
    assign err_pulse  = r_err;

    // Output register, cursor tracking and mode FSM; a new load overrides the
    // valid-clear from a same-cycle transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_NORM;
            r_out_valid   <= 1'b0;
            r_out_txn     <= '0;
            r_row         <= 1'b0;
            r_col         <= '0;
            r_err         <= 1'b0;
`ifdef UART_LCD_FRAMER_AUTOWRAP_EN
            r_wrap_loaded <= 1'b0;
`endif
        end else begin
            r_err <= 1'b0;
            if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_NORM: begin
                    if (w_accept) begin
                        case (w_class)
                            CL_ESC:  r_state <= S_ESC;
                            CL_DROP: r_err   <= 1'b1;
                            default: begin
                                r_out_valid <= 1'b1;
                                r_out_txn   <= w_txn;
                                if (w_class == CL_PRINT) begin
                                    if (w_col_last) begin
                                        r_col <= '0;
                                        r_row <= !r_row;
`ifdef UART_LCD_FRAMER_AUTOWRAP_EN
                                        r_state       <= S_WRAP;
                                        r_wrap_loaded <= 1'b0;
`endif
                                    end else begin
                                        r_col <= r_col + CW'(1);
                                    end
                                end else begin
                                    r_col <= '0;
                                    if (w_class == CL_LF) begin
                                        r_row <= !r_row;
                                    end else if (w_class == CL_FF) begin
                                        r_row <= 1'b0;
                                    end
                                end
                            end
                        endcase
                    end
                end
                S_ESC: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b1;
                        r_out_txn   <= '{rs: 1'b0, data: in_data};
                        r_state     <= S_NORM;
                    end
                end
                S_WRAP: begin
`ifdef UART_LCD_FRAMER_AUTOWRAP_EN
                    // The output register always holds either the wrapping
                    // character or the wrap command while in this state.
                    if (out_ready) begin
                        if (!r_wrap_loaded) begin
                            r_out_valid   <= 1'b1;
                            r_out_txn     <= '{rs: 1'b0, data: line_addr(r_row)};
                            r_wrap_loaded <= 1'b1;
                        end else begin
                            r_state <= S_NORM;
                        end
                    end
`else
                    r_state <= S_NORM;
`endif
                end
                default: r_state <= S_NORM;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_lcd_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_lcd_framer
//  Description : Self-checking bench for uart_lcd_framer. A transaction-queue
//                model predicts outputs every cycle; directed literal checks
//                pin the model; a randomized phase mixes byte classes and
//                FIFO backpressure. Honours UART_LCD_FRAMER_AUTOWRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_lcd_framer;

    localparam int         COLS     = 16;
    localparam int         CW       = $clog2(COLS);
    localparam logic [7:0] ESC_CHAR = 8'h1B;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [8:0]    out_txn;
    logic          cur_row;
    logic [CW-1:0] cur_col;
    logic          err_pulse;

    uart_lcd_framer #(
        .COLS     (COLS),
        .ESC_CHAR (ESC_CHAR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_txn   (out_txn),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .err_pulse (err_pulse)
    );

    int checks = 0;
    int errors = 0;

    // Model: pending transactions in order, cursor as plain integers
    logic [8:0] q_txn[$];
    bit         q_wrap[$];
    bit         m_row;
    int         m_col;
    bit         m_esc;
    bit         m_err;
    int         n_acc;
    bit         started;
    bit         rnd_bp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Input may be taken when the output slot is free or draining and no
    // wrap command is still waiting to leave.
    function automatic bit model_ready();
        bit stall;
        stall = 1'b0;
        foreach (q_wrap[i]) if (q_wrap[i]) stall = 1'b1;
        return (q_txn.size() == 0 || out_ready) && !stall;
    endfunction

    function automatic void push(input logic [8:0] t, input bit w);
        q_txn.push_back(t);
        q_wrap.push_back(w);
    endfunction

    function automatic void apply_byte(input logic [7:0] b);
        if (m_esc) begin
            push({1'b0, b}, 1'b0);
            m_esc = 1'b0;
        end else if (b == ESC_CHAR) begin
            m_esc = 1'b1;
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            push({1'b1, b}, 1'b0);
            m_col = m_col + 1;
            if (m_col == COLS) begin
                m_col = 0;
                m_row = !m_row;
`ifdef UART_LCD_FRAMER_AUTOWRAP_EN
                push({1'b0, (m_row ? 8'hC0 : 8'h80)}, 1'b1);
`endif
            end
        end else if (b == 8'h0D) begin
            push({1'b0, (m_row ? 8'hC0 : 8'h80)}, 1'b0);
            m_col = 0;
        end else if (b == 8'h0A) begin
            push({1'b0, (m_row ? 8'h80 : 8'hC0)}, 1'b0);
            m_row = !m_row;
            m_col = 0;
        end else if (b == 8'h0C) begin
            push(9'h001, 1'b0);
            m_row = 1'b0;
            m_col = 0;
        end else begin
            m_err = 1'b1;
        end
    endfunction

    // Model update at each rising edge: transfer first, then accept
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                q_txn.delete();
                q_wrap.delete();
                m_row = 1'b0;
                m_col = 0;
                m_esc = 1'b0;
                m_err = 1'b0;
            end else begin
                bit rdy;
                rdy   = model_ready();
                m_err = 1'b0;
                if (q_txn.size() > 0 && out_ready) begin
                    void'(q_txn.pop_front());
                    void'(q_wrap.pop_front());
                end
                if (in_valid && rdy) begin
                    apply_byte(in_data);
                    n_acc++;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (started && !rst) begin
                chk("out_valid", 32'(out_valid), 32'(q_txn.size() > 0));
                if (q_txn.size() > 0)
                    chk("out_txn", 32'(out_txn), 32'(q_txn[0]));
                chk("in_ready", 32'(in_ready), 32'(model_ready()));
                chk("cur_row", 32'(cur_row), 32'(m_row));
                chk("cur_col", 32'(cur_col), 32'(m_col));
                chk("err_pulse", 32'(err_pulse), 32'(m_err));
            end
        end
    end

    // Random FIFO backpressure
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one byte and hold it until the model sees it accepted
    task automatic send(input logic [7:0] b);
        int n0;
        n0       = n_acc;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #2;
            if (n_acc != n0) break;
        end
        if (n_acc == n0) chk("accept_timeout", 32'(n_acc), 32'(n0 + 1));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h41;
        out_ready = 1'b1;
        n_acc     = 0;
        started   = 1'b0;
        rnd_bp    = 1'b0;

        // Reset with a byte presented
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_row", 32'(cur_row), 32'h0);
        chk("rst_col", 32'(cur_col), 32'h0);
        chk("rst_err", 32'(err_pulse), 32'h0);
        rst      = 1'b0;
        in_valid = 1'b0;
        started  = 1'b1;
        idle(1);
        chk("rst_no_accept", 32'(out_valid), 32'h0);

        // Printable characters
        send(8'h41);
        chk("A_txn", 32'(out_txn), 32'h141);
        chk("A_col", 32'(cur_col), 32'h1);
        send(8'h48);
        chk("H_txn", 32'(out_txn), 32'h148);
        send(8'h69);
        chk("i_txn", 32'(out_txn), 32'h169);
        chk("Hi_col", 32'(cur_col), 32'h3);
        idle(2);

        // Clear, then two full lines
        send(8'h0C);
        chk("FF_txn", 32'(out_txn), 32'h001);
        for (int line = 0; line < 2; line++) begin
            for (int i = 0; i < COLS; i++) send(8'(8'h41 + i));
            chk("line_row", 32'(cur_row), (line == 0) ? 32'h1 : 32'h0);
            chk("line_col", 32'(cur_col), 32'h0);
`ifdef UART_LCD_FRAMER_AUTOWRAP_EN
            idle(1);
            chk("wrap_txn", 32'(out_txn), (line == 0) ? 32'h0C0 : 32'h080);
            chk("wrap_stall", 32'(in_ready), 32'h0);
            idle(1);
            chk("wrap_done_valid", 32'(out_valid), 32'h0);
            chk("wrap_done_ready", 32'(in_ready), 32'h1);
`else
            idle(1);
            chk("nowrap_valid", 32'(out_valid), 32'h0);
`endif
        end

        // Escape
        send(8'h78);
        send(ESC_CHAR);
        chk("esc_no_txn", 32'(out_valid), 32'h0);
        chk("esc_col", 32'(cur_col), 32'h1);
        send(8'h38);
        chk("esc_txn", 32'(out_txn), 32'h038);
        chk("esc_col2", 32'(cur_col), 32'h1);
        send(ESC_CHAR);
        send(ESC_CHAR);
        chk("esc_esc_txn", 32'(out_txn), 32'h01B);
        idle(2);

        // Backpressure
        out_ready = 1'b0;
        send(8'h48);
        for (int i = 0; i < 5; i++) begin
            chk("bp_txn", 32'(out_txn), 32'h148);
            chk("bp_ready", 32'(in_ready), 32'h0);
            idle(1);
        end
        out_ready = 1'b1;
        idle(1);
        chk("bp_one_xfer", 32'(out_valid), 32'h0);

        // Control and illegal bytes
        send(8'h07);
        chk("bel_err", 32'(err_pulse), 32'h1);
        chk("bel_no_txn", 32'(out_valid), 32'h0);
        idle(1);
        chk("bel_err_end", 32'(err_pulse), 32'h0);
        send(8'h0C);
        chk("ff_txn", 32'(out_txn), 32'h001);
        chk("ff_row", 32'(cur_row), 32'h0);
        chk("ff_col", 32'(cur_col), 32'h0);
        send(8'h0A);
        chk("lf_txn", 32'(out_txn), 32'h0C0);
        chk("lf_row", 32'(cur_row), 32'h1);
        send(8'h0D);
        chk("cr_txn", 32'(out_txn), 32'h0C0);
        chk("cr_col", 32'(cur_col), 32'h0);
        idle(2);

        // Randomized traffic with backpressure
        rnd_bp = 1'b1;
        for (int n = 0; n < 600; n++) begin
            logic [7:0] b;
            case ($urandom_range(0, 11))
                0:       b = ESC_CHAR;
                1:       b = 8'h0D;
                2:       b = 8'h0A;
                3:       b = 8'h0C;
                4:       b = 8'($urandom_range(0, 255));
                5:       b = 8'($urandom_range(0, 31));
                default: b = 8'($urandom_range(32, 126));
            endcase
            send(b);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        rnd_bp    = 1'b0;
        out_ready = 1'b1;
        idle(6);
        chk("drain_valid", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
